// File: rtl/mac_accum4_pkg.sv
// Shared constants for the mac_accum4 multiply-accumulate stage.
package mac_accum4_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int PROD_W = 8;

endpackage

// File: rtl/mac_accum4_array_multiplier.sv
// Combinational 4x4 unsigned array multiplier, 8-bit product.
module array_multiplier
  import mac_accum4_pkg::*;
(
  input  logic [3:0]        i_a,
  input  logic [3:0]        i_b,
  output logic [PROD_W-1:0] o_p
);

  logic [PROD_W-1:0] w_pp [4];

  for (genvar i = 0; i < 4; i++) begin : g_pp
    assign w_pp[i] = {4'b0, i_a & {4{i_b[i]}}} << i;
  end

  assign o_p = w_pp[0] + w_pp[1] + w_pp[2] + w_pp[3];

endmodule

// File: rtl/mac_accum4.sv
// Burst multiply-accumulate: LEN products of 4x4 operands summed
// into an ACC_W-bit accumulator with a sticky carry-out flag.
module mac_accum4
  import mac_accum4_pkg::*;
#(
  parameter int ACC_W = 16,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf,
  output logic             busy
);

  logic [1:0]        r_state;
  logic [LEN_W-1:0]  r_rem;
  logic [PROD_W-1:0] r_prod;
  logic              r_prod_v;
  logic [ACC_W-1:0]  r_acc;
  logic              r_ovf;
  logic              r_out_valid;
  logic [ACC_W-1:0]  r_out_acc;
  logic              r_out_ovf;

  logic              w_in_ready;
  logic              w_accept;
  logic [PROD_W-1:0] w_prod;
  logic [ACC_W:0]    w_sum;

  array_multiplier u_mult (
    .i_a (in_a),
    .i_b (in_b),
    .o_p (w_prod)
  );

  assign w_in_ready = (r_state == S_ACCUM) && (r_rem != '0);
  assign w_accept   = in_valid && w_in_ready;
  assign w_sum      = {1'b0, r_acc} + (ACC_W+1)'(r_prod);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rem       <= '0;
      r_prod      <= '0;
      r_prod_v    <= 1'b0;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_acc   <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      r_prod_v <= w_accept;
      if (w_accept)
        r_prod <= w_prod;
      if (r_prod_v) begin
        r_acc <= w_sum[ACC_W-1:0];
        if (w_sum[ACC_W])
          r_ovf <= 1'b1;
      end
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_rem   <= len;
            r_state <= (len != '0) ? S_ACCUM : S_DONE;
          end
        end
        S_ACCUM: begin
          if (w_accept) begin
            r_rem <= r_rem - LEN_W'(1);
            if (r_rem == LEN_W'(1))
              r_state <= S_FLUSH;
          end
        end
        S_FLUSH: r_state <= S_DONE;
        S_DONE: begin
          // first DONE cycle captures the settled sum into the output regs
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_out_acc   <= r_acc;
            r_out_ovf   <= r_ovf;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign busy      = (r_state != S_IDLE);
  assign out_valid = r_out_valid;
  assign out_acc   = r_out_acc;
  assign out_ovf   = r_out_ovf;

endmodule
